// File: rtl/rc_mem_port_pkg.sv
// rc_mem_port_pkg: shared types and constants for the reconfigurable-cell memory port.
//   mem_port_state_t : FSM state encoding of rc_mem_port
//   DP_WIDTH         : cell datapath width
//   RC_MEM_BE_WIDTH  : byte-enable width of one datapath word
package rc_mem_port_pkg;

  localparam int DP_WIDTH        = 32;
  localparam int RC_MEM_BE_WIDTH = DP_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_port_state_t;

endpackage

// File: rtl/rc_mem_port.sv
// rc_mem_port: memory-side responder for one reconfigurable cell.
// Accepts an LWD/LWI/SWD/SWI request from the cell, resolves the address
// (indirect operand or internal post-incremented pointer) and runs a single
// req/gnt/rvalid transaction on the shared data bus.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   rc_req_i .. rc_inc_i    cell request (held until rc_rvalid_o)
//   rc_rdata_o              registered load data
//   rc_rvalid_o             one-cycle completion pulse
//   rc_busy_o               transaction in flight
//   ptr_we_i, ptr_wdata_i   host load of the direct-address pointer
//   ptr_o                   current pointer
//   bus_*                   data-bus master side
//
// state | meaning
// IDLE  | waiting for rc_req_i; request fields latched on accept
// REQ   | bus_req_o asserted, waiting for bus_gnt_i
// WAIT  | granted, waiting for bus_rvalid_i
// DONE  | rc_rvalid_o pulse; no request accepted here
module rc_mem_port
  import rc_mem_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INC_WIDTH  = 13
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rc_req_i,
  input  logic                    rc_wen_i,
  input  logic                    rc_ind_i,
  input  logic [DATA_WIDTH-1:0]   rc_add_i,
  input  logic [DATA_WIDTH-1:0]   rc_wdata_i,
  input  logic [INC_WIDTH-1:0]    rc_inc_i,
  output logic [DATA_WIDTH-1:0]   rc_rdata_o,
  output logic                    rc_rvalid_o,
  output logic                    rc_busy_o,
  input  logic                    ptr_we_i,
  input  logic [ADDR_WIDTH-1:0]   ptr_wdata_i,
  output logic [ADDR_WIDTH-1:0]   ptr_o,
  output logic                    bus_req_o,
  input  logic                    bus_gnt_i,
  output logic                    bus_we_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  output logic [ADDR_WIDTH-1:0]   bus_add_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_rvalid_i
);

  // Clears the byte-offset bits so every bus access is word aligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_WIDTH/8 - 1));

  mem_port_state_t state, state_nxt;

  logic                  lat_we;
  logic                  lat_ind;
  logic [ADDR_WIDTH-1:0] lat_add;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [INC_WIDTH-1:0]  lat_inc;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] inc_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus_req_o   = 1'b0;
    rc_rvalid_o = 1'b0;
    rc_busy_o   = 1'b1;
    case (state)
      IDLE: begin
        rc_busy_o = 1'b0;
        if (rc_req_i) state_nxt = REQ;
      end
      REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus_rvalid_i) state_nxt = DONE;
      end
      DONE: begin
        rc_rvalid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once on accept so the bus side never sees
  // the live rc_* inputs and stays stable through a grant stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_we    <= 1'b0;
      lat_ind   <= 1'b0;
      lat_add   <= '0;
      lat_wdata <= '0;
      lat_inc   <= '0;
    end else if (state == IDLE && rc_req_i) begin
      lat_we    <= ~rc_wen_i;
      lat_ind   <= rc_ind_i;
      lat_add   <= rc_ind_i ? ADDR_WIDTH'(rc_add_i) : ptr;
      lat_wdata <= rc_wdata_i;
      lat_inc   <= rc_inc_i;
    end
  end

  assign inc_ext = {{(ADDR_WIDTH-INC_WIDTH){lat_inc[INC_WIDTH-1]}}, lat_inc};

  // Host load wins over a post-increment landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                   ptr <= '0;
    else if (ptr_we_i)                           ptr <= ptr_wdata_i;
    else if (state == REQ && bus_gnt_i && !lat_ind) ptr <= ptr + inc_ext;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                                            rc_rdata_o <= '0;
    else if (state == WAIT && bus_rvalid_i && !lat_we)    rc_rdata_o <= bus_rdata_i;
  end

  assign ptr_o       = ptr;
  assign bus_we_o    = lat_we;
  assign bus_be_o    = '1;
  assign bus_add_o   = lat_add & ALIGN_MASK;
  assign bus_wdata_o = lat_wdata;

endmodule

// File: tb/tb_rc_mem_port.sv
// tb_rc_mem_port: directed bench for rc_mem_port with a scoreboard of
// expected bus transactions and load results.
module tb_rc_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rc_req = 1'b0, rc_wen = 1'b1, rc_ind = 1'b0;
  logic [31:0] rc_add = '0, rc_wdata = '0;
  logic [12:0] rc_inc = '0;
  logic [31:0] rc_rdata;
  logic        rc_rvalid, rc_busy;
  logic        ptr_we = 1'b0;
  logic [31:0] ptr_wdata = '0, ptr;
  logic        bus_req, bus_gnt = 1'b0, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_add, bus_wdata, bus_rdata = '0;
  logic        bus_rvalid = 1'b0;

  rc_mem_port dut (
    .clk_i(clk), .rst_i(rst),
    .rc_req_i(rc_req), .rc_wen_i(rc_wen), .rc_ind_i(rc_ind),
    .rc_add_i(rc_add), .rc_wdata_i(rc_wdata), .rc_inc_i(rc_inc),
    .rc_rdata_o(rc_rdata), .rc_rvalid_o(rc_rvalid), .rc_busy_o(rc_busy),
    .ptr_we_i(ptr_we), .ptr_wdata_i(ptr_wdata), .ptr_o(ptr),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_we_o(bus_we),
    .bus_be_o(bus_be), .bus_add_o(bus_add), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .bus_rvalid_i(bus_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;
  logic [31:0] model_ptr   = '0;
  logic [31:0] model_rdata = '0;

  // Counts every bus handshake the DUT completes.
  always @(posedge clk) if (!rst && bus_req && bus_gnt) n_hs++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ptr(input logic [31:0] v);
    ptr_we = 1'b1; ptr_wdata = v;
    step();
    ptr_we = 1'b0;
    model_ptr = v;
    chk("ptr_load", ptr, model_ptr);
  endtask

  task automatic do_txn(input logic ind, input logic wen, input logic [31:0] add,
                        input logic [31:0] wdata, input logic [12:0] inc,
                        input int gnt_delay, input logic [31:0] rdata,
                        input logic ld_at_gnt, input logic [31:0] ld_val);
    exp_t e;
    e.we    = ~wen;
    e.add   = (ind ? add : model_ptr) & 32'hFFFF_FFFC;
    e.wdata = wdata;
    if (wen) model_rdata = rdata;
    e.rdata = model_rdata;
    sb_q.push_back(e);

    rc_req = 1'b1; rc_wen = wen; rc_ind = ind; rc_add = add; rc_wdata = wdata; rc_inc = inc;
    step();
    chk("req_busy", rc_busy, 1'b1);
    for (int i = 0; i < gnt_delay; i++) begin
      chk("stall_req",  bus_req, 1'b1);
      chk("stall_add",  bus_add, sb_q[0].add);
      chk("stall_we",   bus_we, sb_q[0].we);
      chk("stall_wd",   bus_wdata, sb_q[0].wdata);
      chk("stall_busy", rc_busy, 1'b1);
      chk("stall_ptr",  ptr, model_ptr);
      step();
    end
    chk("gnt_req",   bus_req, 1'b1);
    chk("gnt_we",    bus_we, sb_q[0].we);
    chk("gnt_add",   bus_add, sb_q[0].add);
    chk("gnt_wdata", bus_wdata, sb_q[0].wdata);
    chk("gnt_be",    bus_be, 4'hF);
    bus_gnt = 1'b1;
    if (ld_at_gnt) begin ptr_we = 1'b1; ptr_wdata = ld_val; end
    step();
    bus_gnt = 1'b0; ptr_we = 1'b0;
    if (ld_at_gnt)  model_ptr = ld_val;
    else if (!ind)  model_ptr = model_ptr + {{19{inc[12]}}, inc};
    chk("wait_ptr",    ptr, model_ptr);
    chk("wait_req",    bus_req, 1'b0);
    chk("wait_rvalid", rc_rvalid, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = rdata;
    step();
    bus_rvalid = 1'b0; bus_rdata = 32'h0BAD_0BAD;
    e = sb_q.pop_front();
    chk("done_rvalid", rc_rvalid, 1'b1);
    chk("done_rdata",  rc_rdata, e.rdata);
    // rc_req stays high through DONE and must not be re-accepted.
    step();
    chk("post_rvalid", rc_rvalid, 1'b0);
    chk("post_busy",   rc_busy, 1'b0);
    chk("post_req",    bus_req, 1'b0);
    rc_req = 1'b0;
    step();
    chk("idle_req", bus_req, 1'b0);
  endtask

  initial begin
    int hs_exp;
    hs_exp = 0;
    rst = 1'b1;
    step(); step();
    chk("rst_ptr",    ptr, 32'h0);
    chk("rst_rdata",  rc_rdata, 32'h0);
    chk("rst_rvalid", rc_rvalid, 1'b0);
    chk("rst_busy",   rc_busy, 1'b0);
    chk("rst_req",    bus_req, 1'b0);
    chk("rst_we",     bus_we, 1'b0);
    chk("rst_add",    bus_add, 32'h0);
    chk("rst_wdata",  bus_wdata, 32'h0);
    rst = 1'b0;
    step();

    // Indirect load.
    do_txn(1'b1, 1'b1, 32'h1004, 32'h0, 13'd0, 0, 32'hDEAD_BEEF, 1'b0, 32'h0); hs_exp++;
    // Direct stores with post-increment.
    load_ptr(32'h2000);
    do_txn(1'b0, 1'b0, 32'h0, 32'h55, 13'd4, 0, 32'h1111_1111, 1'b0, 32'h0); hs_exp++;
    do_txn(1'b0, 1'b0, 32'h0, 32'h66, 13'd4, 0, 32'h2222_2222, 1'b0, 32'h0); hs_exp++;
    chk("ptr_after_stores", ptr, 32'h2008);
    // Negative increment with wrap, then misaligned indirect.
    load_ptr(32'h0);
    do_txn(1'b0, 1'b1, 32'h0, 32'h0, 13'h1FFC, 0, 32'h1234_5678, 1'b0, 32'h0); hs_exp++;
    chk("ptr_wrap_neg", ptr, 32'hFFFF_FFFC);
    do_txn(1'b1, 1'b1, 32'h1003, 32'h0, 13'd0, 0, 32'hCAFE_F00D, 1'b0, 32'h0); hs_exp++;
    // Grant stall of 5 cycles on a direct store; pointer wraps upward.
    do_txn(1'b0, 1'b0, 32'h0, 32'hA5A5_0001, 13'd8, 5, 32'h3333_3333, 1'b0, 32'h0); hs_exp++;
    chk("ptr_wrap_pos", ptr, 32'h4);
    // Host pointer load in the grant cycle wins over post-increment.
    do_txn(1'b0, 1'b1, 32'h0, 32'h0, 13'd4, 1, 32'h7777_8888, 1'b1, 32'h3000); hs_exp++;
    chk("ptr_priority", ptr, 32'h3000);

    // Reset while in WAIT, followed by a late response.
    rc_req = 1'b1; rc_wen = 1'b1; rc_ind = 1'b1; rc_add = 32'h500;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; hs_exp++;
    rc_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_req",  bus_req, 1'b0);
    chk("rstw_busy", rc_busy, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 32'hBADD_BADD;
    step();
    bus_rvalid = 1'b0;
    chk("rstw_rvalid", rc_rvalid, 1'b0);
    chk("rstw_busy2",  rc_busy, 1'b0);
    step();
    chk("rstw_rvalid2", rc_rvalid, 1'b0);
    chk("rstw_rdata",   rc_rdata, 32'h0);
    model_ptr = '0; model_rdata = '0;
    // Fresh traffic after reset.
    do_txn(1'b1, 1'b1, 32'h40, 32'h0, 13'd0, 0, 32'hA5A5_A5A5, 1'b0, 32'h0); hs_exp++;
    do_txn(1'b0, 1'b0, 32'h0, 32'h99, 13'd4, 2, 32'h4444_4444, 1'b0, 32'h0); hs_exp++;
    chk("ptr_after_reset", ptr, 32'h4);

    chk("handshakes", 32'(n_hs), 32'(hs_exp));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
